// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access stage of a 5-stage MIPS pipeline. It holds the EX/MEM
//   register, a byte-addressable data memory, the branch decision and the
//   MEM/WB register. It also exposes the EX/MEM and MEM/WB destination and
//   regWrite values to the forwarding unit.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_enable                1 = pipeline advances; 0 = hold and suppress stores
//   i_flush                 clear EX/MEM control bits at capture (bubble)
//   i_aluResult, i_zero     ALU result/effective address and zero flag
//   i_storeData             store data (forwarded rt)
//   i_branchTarget          computed branch target
//   i_rd                    destination register index
//   i_memRead .. i_branch   control bits from execute
//   i_memWidth              00 byte, 01 half, 1x word
//   i_loadUnsigned          1 = zero-extend narrow loads
//   o_*_EX_MEM              EX/MEM forwarding sources
//   o_pcSrc, o_branchTarget branch decision and target from EX/MEM
//   o_readData .. o_misaligned  MEM/WB register contents
//
// There is no FSM and no valid/ready handshake: i_enable is a global
// advance strobe for both pipeline registers and the memory write port.

module mem_access_stage #(
    parameter int N_BITS     = 32,
    parameter int N_BITS_REG = 5,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [N_BITS-1:0]     i_aluResult,
    input  logic                  i_zero,
    input  logic [N_BITS-1:0]     i_storeData,
    input  logic [N_BITS-1:0]     i_branchTarget,
    input  logic [N_BITS_REG-1:0] i_rd,
    input  logic                  i_memRead,
    input  logic                  i_memWrite,
    input  logic                  i_memToReg,
    input  logic                  i_regWrite,
    input  logic                  i_branch,
    input  logic [1:0]            i_memWidth,
    input  logic                  i_loadUnsigned,
    output logic [N_BITS-1:0]     o_aluResult_EX_MEM,
    output logic [N_BITS_REG-1:0] o_rd_EX_MEM,
    output logic                  o_regWrite_EX_MEM,
    output logic                  o_pcSrc,
    output logic [N_BITS-1:0]     o_branchTarget,
    output logic [N_BITS-1:0]     o_readData,
    output logic [N_BITS-1:0]     o_aluResult_MEM_WB,
    output logic [N_BITS_REG-1:0] o_rd_MEM_WB,
    output logic                  o_regWrite_MEM_WB,
    output logic                  o_memToReg_MEM_WB,
    output logic                  o_misaligned
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    // EX/MEM register
    logic [N_BITS-1:0]     em_alu;
    logic                  em_zero;
    logic [N_BITS-1:0]     em_store;
    logic [N_BITS-1:0]     em_target;
    logic [N_BITS_REG-1:0] em_rd;
    logic                  em_mem_read;
    logic                  em_mem_write;
    logic                  em_mem_to_reg;
    logic                  em_reg_write;
    logic                  em_branch;
    logic [1:0]            em_width;
    logic                  em_unsigned;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            em_alu        <= '0;
            em_zero       <= 1'b0;
            em_store      <= '0;
            em_target     <= '0;
            em_rd         <= '0;
            em_mem_read   <= 1'b0;
            em_mem_write  <= 1'b0;
            em_mem_to_reg <= 1'b0;
            em_reg_write  <= 1'b0;
            em_branch     <= 1'b0;
            em_width      <= 2'b00;
            em_unsigned   <= 1'b0;
        end else if (i_enable) begin
            em_alu        <= i_aluResult;
            em_zero       <= i_zero;
            em_store      <= i_storeData;
            em_target     <= i_branchTarget;
            em_rd         <= i_rd;
            em_width      <= i_memWidth;
            em_unsigned   <= i_loadUnsigned;
            // A flush turns the captured instruction into a bubble: data
            // still loads, but nothing it does has architectural effect.
            em_mem_read   <= i_memRead   & ~i_flush;
            em_mem_write  <= i_memWrite  & ~i_flush;
            em_mem_to_reg <= i_memToReg  & ~i_flush;
            em_reg_write  <= i_regWrite  & ~i_flush;
            em_branch     <= i_branch    & ~i_flush;
        end
    end

    // Address decode: upper address bits are ignored, so accesses wrap.
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             is_byte;
    logic             is_half;
    logic             bad_align;
    logic             access_misaligned;

    assign idx               = em_alu[IDX_W+1:2];
    assign lane              = em_alu[1:0];
    assign is_byte           = (em_width == 2'b00);
    assign is_half           = (em_width == 2'b01);
    assign bad_align         = is_half ? lane[0] : (!is_byte && lane != 2'b00);
    assign access_misaligned = (em_mem_read | em_mem_write) & bad_align;

    // Data memory (contents are deliberately not reset).
    logic [N_BITS-1:0] mem [MEM_DEPTH];
    logic [N_BITS-1:0] mem_word;
    logic [3:0]        byte_en;
    logic [N_BITS-1:0] wdata;
    logic              do_write;

    assign mem_word = mem[idx];

    always_comb begin
        byte_en = 4'b1111;
        wdata   = em_store;
        if (is_byte) begin
            byte_en = 4'b0001 << lane;
            wdata   = {4{em_store[7:0]}};
        end else if (is_half) begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{em_store[15:0]}};
        end
    end

    // i_reset is included so a store racing an asserted reset is dropped.
    assign do_write = em_mem_write & ~bad_align & i_enable & i_reset;

    always_ff @(posedge i_clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Load path: extract the addressed byte/half, then extend.
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [N_BITS-1:0] load_data;

    always_comb begin
        byte_sel = mem_word[7:0];
        case (lane)
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            2'd3:    byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
        half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = mem_word;
        if (is_byte) begin
            load_data = em_unsigned ? {{(N_BITS-8){1'b0}}, byte_sel}
                                    : {{(N_BITS-8){byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            load_data = em_unsigned ? {{(N_BITS-16){1'b0}}, half_sel}
                                    : {{(N_BITS-16){half_sel[15]}}, half_sel};
        end
    end

    // MEM/WB register
    logic [N_BITS-1:0]     mw_read_data;
    logic [N_BITS-1:0]     mw_alu;
    logic [N_BITS_REG-1:0] mw_rd;
    logic                  mw_reg_write;
    logic                  mw_mem_to_reg;
    logic                  mw_misaligned;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mw_read_data  <= '0;
            mw_alu        <= '0;
            mw_rd         <= '0;
            mw_reg_write  <= 1'b0;
            mw_mem_to_reg <= 1'b0;
            mw_misaligned <= 1'b0;
        end else if (i_enable) begin
            mw_read_data  <= load_data;
            mw_alu        <= em_alu;
            mw_rd         <= em_rd;
            // A misaligned load must not write back garbage.
            mw_reg_write  <= em_reg_write & ~(em_mem_read & access_misaligned);
            mw_mem_to_reg <= em_mem_to_reg;
            mw_misaligned <= access_misaligned;
        end
    end

    assign o_aluResult_EX_MEM = em_alu;
    assign o_rd_EX_MEM        = em_rd;
    assign o_regWrite_EX_MEM  = em_reg_write;
    assign o_pcSrc            = em_branch & em_zero;
    assign o_branchTarget     = em_target;
    assign o_readData         = mw_read_data;
    assign o_aluResult_MEM_WB = mw_alu;
    assign o_rd_MEM_WB        = mw_rd;
    assign o_regWrite_MEM_WB  = mw_reg_write;
    assign o_memToReg_MEM_WB  = mw_mem_to_reg;
    assign o_misaligned       = mw_misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: reset checks, memory initialisation,
// a table of directed vectors, hand-written multi-cycle sequences and
// randomized traffic compared against a byte-array reference model.

module tb_mem_access_stage;

    localparam int NB    = 32;
    localparam int NR    = 5;
    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          en, flush, zero, mr, mw, m2r, rw, br, lu;
    logic [NB-1:0] alu, sd, bt;
    logic [NR-1:0] rd;
    logic [1:0]    width;

    logic [NB-1:0] o_alu_em, o_bt, o_rdata, o_alu_mw;
    logic [NR-1:0] o_rd_em, o_rd_mw;
    logic          o_rw_em, o_pcsrc, o_rw_mw, o_m2r_mw, o_mis;

    mem_access_stage #(.N_BITS(NB), .N_BITS_REG(NR), .MEM_DEPTH(DEPTH)) dut (
        .i_clk              (clk),
        .i_reset            (rst_n),
        .i_enable           (en),
        .i_flush            (flush),
        .i_aluResult        (alu),
        .i_zero             (zero),
        .i_storeData        (sd),
        .i_branchTarget     (bt),
        .i_rd               (rd),
        .i_memRead          (mr),
        .i_memWrite         (mw),
        .i_memToReg         (m2r),
        .i_regWrite         (rw),
        .i_branch           (br),
        .i_memWidth         (width),
        .i_loadUnsigned     (lu),
        .o_aluResult_EX_MEM (o_alu_em),
        .o_rd_EX_MEM        (o_rd_em),
        .o_regWrite_EX_MEM  (o_rw_em),
        .o_pcSrc            (o_pcsrc),
        .o_branchTarget     (o_bt),
        .o_readData         (o_rdata),
        .o_aluResult_MEM_WB (o_alu_mw),
        .o_rd_MEM_WB        (o_rd_mw),
        .o_regWrite_MEM_WB  (o_rw_mw),
        .o_memToReg_MEM_WB  (o_m2r_mw),
        .o_misaligned       (o_mis)
    );

    // ---------------- instruction records ----------------
    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] sd;
        logic [31:0] bt;
        logic [4:0]  rd;
        logic        mr, mw, m2r, rw, br;
        logic [1:0]  w;
        logic        lu;
        logic        flush;
        logic        en;
    } in_t;

    typedef struct {
        in_t         i;
        logic        pcsrc;
        logic        rw_em;
        logic        rdv;
        logic [31:0] rdata;
        logic        rw_mw;
        logic        m2r_mw;
        logic        mis;
    } vec_t;

    function automatic in_t f_nop();
        in_t x = '0;
        x.en = 1'b1;
        return x;
    endfunction

    function automatic in_t f_st(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        in_t x = f_nop();
        x.w = w; x.alu = a; x.sd = d; x.mw = 1'b1;
        return x;
    endfunction

    function automatic in_t f_ld(input logic [1:0] w, input logic [31:0] a, input logic [4:0] r,
                                 input logic u);
        in_t x = f_nop();
        x.w = w; x.alu = a; x.rd = r; x.lu = u; x.mr = 1'b1; x.m2r = 1'b1; x.rw = 1'b1;
        return x;
    endfunction

    function automatic in_t f_alu(input logic [31:0] v, input logic [4:0] r, input logic fl);
        in_t x = f_nop();
        x.alu = v; x.rd = r; x.rw = 1'b1; x.flush = fl; x.w = 2'b10;
        return x;
    endfunction

    function automatic in_t f_beq(input logic z, input logic [31:0] t, input logic fl);
        in_t x = f_nop();
        x.br = 1'b1; x.zero = z; x.bt = t; x.flush = fl;
        return x;
    endfunction

    function automatic vec_t v(input in_t i, input logic pc, input logic rwem, input logic rdv,
                               input logic [31:0] rdata, input logic rwmw, input logic m2r_,
                               input logic mis);
        vec_t r;
        r.i = i; r.pcsrc = pc; r.rw_em = rwem; r.rdv = rdv; r.rdata = rdata;
        r.rw_mw = rwmw; r.m2r_mw = m2r_; r.mis = mis;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [NB-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu_em"}, o_alu_em, 0);
        chk({tag, "_rd_em"}, 32'(o_rd_em), 0);
        chk({tag, "_rw_em"}, 32'(o_rw_em), 0);
        chk({tag, "_pcsrc"}, 32'(o_pcsrc), 0);
        chk({tag, "_bt"}, o_bt, 0);
        chk({tag, "_rdata"}, o_rdata, 0);
        chk({tag, "_alu_mw"}, o_alu_mw, 0);
        chk({tag, "_rd_mw"}, 32'(o_rd_mw), 0);
        chk({tag, "_rw_mw"}, 32'(o_rw_mw), 0);
        chk({tag, "_m2r_mw"}, 32'(o_m2r_mw), 0);
        chk({tag, "_mis"}, 32'(o_mis), 0);
    endtask

    // ---------------- reference model ----------------
    // Memory is a flat byte array; an instruction is modelled as a record
    // that moves from the "in EX/MEM" slot to "results in MEM/WB".
    logic [7:0]  mb [DEPTH*4];
    in_t         exm;
    logic [31:0] m_rdata, m_alu;
    logic [4:0]  m_rd;
    logic        m_known, m_rw, m_m2r, m_mis;
    bit          init_phase = 1'b0;

    task automatic model_reset();
        exm = '0; m_rdata = 0; m_known = 1'b1; m_alu = 0; m_rd = 0;
        m_rw = 1'b0; m_m2r = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_edge(input in_t x);
        int a, sz;
        logic [31:0] val;
        logic mis;
        if (!x.en) return;
        a   = int'(exm.alu % 32'(DEPTH*4));
        sz  = (exm.w == 2'b00) ? 1 : (exm.w == 2'b01) ? 2 : 4;
        mis = (exm.mr || exm.mw) && (a % sz != 0);
        if (a % sz == 0) begin
            val = 0;
            for (int k = 0; k < sz; k++) val |= 32'(mb[a+k]) << (8*k);
            if (!exm.lu && sz < 4 && val[8*sz-1]) val |= ~((32'd1 << (8*sz)) - 1);
            m_rdata = val;
            m_known = !init_phase;
        end else begin
            m_known = 1'b0;
        end
        m_alu = exm.alu;
        m_rd  = exm.rd;
        m_rw  = exm.rw && !(exm.mr && mis);
        m_m2r = exm.m2r;
        m_mis = mis;
        if (exm.mw && !mis)
            for (int k = 0; k < sz; k++) mb[a+k] = exm.sd[8*k +: 8];
        exm = x;
        if (x.flush) begin
            exm.mr = 1'b0; exm.mw = 1'b0; exm.m2r = 1'b0; exm.rw = 1'b0; exm.br = 1'b0;
        end
    endtask

    task automatic check_model();
        chk("m_alu_em", o_alu_em, exm.alu);
        chk("m_rd_em", 32'(o_rd_em), 32'(exm.rd));
        chk("m_rw_em", 32'(o_rw_em), 32'(exm.rw));
        chk("m_pcsrc", 32'(o_pcsrc), 32'(exm.br & exm.zero));
        chk("m_bt", o_bt, exm.bt);
        chk("m_alu_mw", o_alu_mw, m_alu);
        chk("m_rd_mw", 32'(o_rd_mw), 32'(m_rd));
        chk("m_rw_mw", 32'(o_rw_mw), 32'(m_rw));
        chk("m_m2r_mw", 32'(o_m2r_mw), 32'(m_m2r));
        chk("m_mis", 32'(o_mis), 32'(m_mis));
        if (m_known) begin
            exp_q.push_back(m_rdata);
            chk("m_rdata", o_rdata, exp_q.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input in_t x);
        en = x.en; flush = x.flush; alu = x.alu; zero = x.zero; sd = x.sd; bt = x.bt;
        rd = x.rd; mr = x.mr; mw = x.mw; m2r = x.m2r; rw = x.rw; br = x.br;
        width = x.w; lu = x.lu;
    endtask

    task automatic step(input in_t x);
        drive(x);
        @(posedge clk);
        #1;
        model_edge(x);
        check_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    vec_t tbl[25];
    in_t  prev, hold;

    initial begin
        tbl[0]  = v(f_st(2'b10, 32'h10, 32'hDEADBEEF), 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(f_ld(2'b10, 32'h10, 5'd3, 1'b0),   0, 1, 0, 0, 0, 0, 0);
        tbl[2]  = v(f_nop(),                            0, 0, 1, 32'hDEADBEEF, 1, 1, 0);
        tbl[3]  = v(f_st(2'b10, 32'h10, 32'h0),        0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = v(f_st(2'b00, 32'h13, 32'hABCDEF80), 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = v(f_ld(2'b00, 32'h13, 5'd4, 1'b0),   0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = v(f_ld(2'b00, 32'h13, 5'd5, 1'b1),   0, 1, 1, 32'hFFFFFF80, 1, 1, 0);
        tbl[7]  = v(f_ld(2'b10, 32'h10, 5'd6, 1'b0),   0, 1, 1, 32'h00000080, 1, 1, 0);
        tbl[8]  = v(f_st(2'b01, 32'h22, 32'hFFFF1234), 0, 0, 1, 32'h80000000, 1, 1, 0);
        tbl[9]  = v(f_ld(2'b10, 32'h20, 5'd7, 1'b0),   0, 1, 0, 0, 0, 0, 0);
        tbl[10] = v(f_st(2'b01, 32'h21, 32'h00005678), 0, 0, 1, 32'h12340000, 1, 1, 0);
        tbl[11] = v(f_ld(2'b10, 32'h20, 5'd8, 1'b0),   0, 1, 0, 0, 0, 0, 1);
        tbl[12] = v(f_ld(2'b10, 32'h22, 5'd9, 1'b0),   0, 1, 1, 32'h12340000, 1, 1, 0);
        tbl[13] = v(f_nop(),                            0, 0, 0, 0, 0, 1, 1);
        tbl[14] = v(f_ld(2'b01, 32'h22, 5'd10, 1'b0),  0, 1, 0, 0, 0, 0, 0);
        tbl[15] = v(f_st(2'b01, 32'h20, 32'h00008001), 0, 0, 1, 32'h00001234, 1, 1, 0);
        tbl[16] = v(f_ld(2'b01, 32'h20, 5'd11, 1'b0),  0, 1, 0, 0, 0, 0, 0);
        tbl[17] = v(f_ld(2'b01, 32'h20, 5'd12, 1'b1),  0, 1, 1, 32'hFFFF8001, 1, 1, 0);
        tbl[18] = v(f_beq(1'b1, 32'h40, 1'b0),         1, 0, 1, 32'h00008001, 1, 1, 0);
        tbl[19] = v(f_alu(32'h55, 5'd13, 1'b1),        0, 0, 0, 0, 0, 0, 0);
        tbl[20] = v(f_alu(32'h66, 5'd14, 1'b0),        0, 1, 0, 0, 0, 0, 0);
        tbl[21] = v(f_beq(1'b0, 32'h80, 1'b0),         0, 0, 0, 0, 1, 0, 0);
        tbl[22] = v(f_beq(1'b1, 32'hC0, 1'b1),         0, 0, 0, 0, 0, 0, 0);
        tbl[23] = v(f_ld(2'b00, 32'h13, 5'd2, 1'b1),   0, 1, 0, 0, 0, 0, 0);
        tbl[24] = v(f_nop(),                            0, 0, 1, 32'h00000080, 1, 1, 0);

        // Reset state
        drive(f_nop());
        model_reset();
        #12;
        chk_zero("reset");
        rst_n = 1'b1;

        // Bring memory to a known all-zero state
        init_phase = 1'b1;
        for (int i = 0; i < DEPTH; i++) step(f_st(2'b10, 32'(i*4), 32'h0));
        step(f_nop());
        init_phase = 1'b0;
        step(f_nop());

        // Directed table
        prev = f_nop();
        for (int r = 0; r < 25; r++) begin
            step(tbl[r].i);
            chk($sformatf("row%0d_alu_em", r), o_alu_em, tbl[r].i.alu);
            chk($sformatf("row%0d_bt", r), o_bt, tbl[r].i.bt);
            chk($sformatf("row%0d_pcsrc", r), 32'(o_pcsrc), 32'(tbl[r].pcsrc));
            chk($sformatf("row%0d_rw_em", r), 32'(o_rw_em), 32'(tbl[r].rw_em));
            chk($sformatf("row%0d_alu_mw", r), o_alu_mw, prev.alu);
            chk($sformatf("row%0d_rd_mw", r), 32'(o_rd_mw), 32'(prev.rd));
            chk($sformatf("row%0d_rw_mw", r), 32'(o_rw_mw), 32'(tbl[r].rw_mw));
            chk($sformatf("row%0d_m2r_mw", r), 32'(o_m2r_mw), 32'(tbl[r].m2r_mw));
            chk($sformatf("row%0d_mis", r), 32'(o_mis), 32'(tbl[r].mis));
            if (tbl[r].rdv) chk($sformatf("row%0d_rdata", r), o_rdata, tbl[r].rdata);
            prev = tbl[r].i;
        end

        // Enable low for three cycles with a store pending
        step(f_st(2'b10, 32'h40, 32'hCAFEF00D));
        hold = f_ld(2'b10, 32'h44, 5'd15, 1'b0);
        hold.en = 1'b0;
        hold.flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(hold);
            chk("hold_alu_em", o_alu_em, 32'h40);
            chk("hold_rw_em", 32'(o_rw_em), 0);
            chk("hold_rw_mw", 32'(o_rw_mw), 0);
            chk("hold_alu_mw", o_alu_mw, 32'h0);
        end
        step(f_ld(2'b10, 32'h40, 5'd15, 1'b0));
        step(f_nop());
        chk("hold_rdata", o_rdata, 32'hCAFEF00D);
        chk("hold_rd_mw", 32'(o_rd_mw), 15);

        // Asynchronous reset mid-stream drops a pending store
        step(f_st(2'b10, 32'h80, 32'h11111111));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("held_rst");
        #2;
        rst_n = 1'b1;
        model_reset();
        step(f_ld(2'b10, 32'h80, 5'd1, 1'b0));
        step(f_nop());
        chk("rst_drop_rdata", o_rdata, 32'h0);
        step(f_st(2'b10, 32'h84, 32'h00000022));
        step(f_ld(2'b10, 32'h84, 5'd2, 1'b0));
        step(f_nop());
        chk("rst_after_rdata", o_rdata, 32'h22);

        // Randomized traffic with wrapping upper address bits
        for (int n = 0; n < 400; n++) begin
            in_t x;
            int kind, sz;
            logic [31:0] a;
            kind = $urandom_range(0, 8);
            x = f_nop();
            x.w = 2'($urandom_range(0, 3));
            sz = (x.w == 2'b00) ? 1 : (x.w == 2'b01) ? 2 : 4;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) a = a - (a % 32'(sz));
            x.alu = ($urandom & 32'hFFFFFC00) | a;
            x.rd = 5'($urandom_range(0, 31));
            x.sd = $urandom;
            x.bt = $urandom;
            x.zero = 1'($urandom_range(0, 1));
            x.lu = 1'($urandom_range(0, 1));
            case (kind)
                0, 1, 2: x.mw = 1'b1;
                3, 4, 5: begin x.mr = 1'b1; x.m2r = 1'b1; x.rw = 1'b1; end
                6:       x.rw = 1'b1;
                7:       x.br = 1'b1;
                default: ;
            endcase
            x.en = ($urandom_range(0, 9) != 0);
            x.flush = ($urandom_range(0, 9) == 0);
            step(x);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
